// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: op selects, opcodes and field positions.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_ORR     = 4'd3,
    OP_LDUR    = 4'd4,
    OP_STUR    = 4'd5,
    OP_LSL     = 4'd6,
    OP_LSR     = 4'd7,
    OP_B       = 4'd8,
    OP_CBZ     = 4'd9,
    OP_CBNZ    = 4'd10,
    OP_ADDI    = 4'd11,
    OP_SUBI    = 4'd12,
    OP_ANDI    = 4'd13,
    OP_ORRI    = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_sel_e;

  // Opcodes, shared with the control-unit decoder
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;

  // Field LSB positions per format
  localparam int unsigned RD_LSB     = 0;
  localparam int unsigned RN_LSB     = 5;
  localparam int unsigned SHAMT_LSB  = 10;
  localparam int unsigned RM_LSB     = 16;
  localparam int unsigned R_OPC_LSB  = 21;
  localparam int unsigned I_IMM_LSB  = 10;
  localparam int unsigned I_OPC_LSB  = 22;
  localparam int unsigned D_IMM_LSB  = 12;
  localparam int unsigned D_OPC_LSB  = 21;
  localparam int unsigned B_OPC_LSB  = 26;
  localparam int unsigned CB_IMM_LSB = 5;
  localparam int unsigned CB_OPC_LSB = 24;

  // True when imm[25:n-1] are all equal, i.e. imm is representable in n signed bits
  function automatic logic fits_signed(input logic [25:0] imm, input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = n - 1; i < 26; i++) begin
      if (imm[i] != imm[25]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/legv8_encode.sv
// Combinational LEGv8 instruction encoder with immediate range checking.
module legv8_encode
  import legv8_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [31:0] r_regs;
  logic [31:0] r_shift;
  logic [31:0] i_body;
  logic [31:0] d_body;
  logic [31:0] cb_body;

  // Shared field placement for each format body
  always_comb begin
    r_regs  = (32'(rm) << RM_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(rn) << RN_LSB) | (32'(rd) << RD_LSB);
    r_shift = (32'(shamt) << SHAMT_LSB) | (32'(rn) << RN_LSB) | (32'(rd) << RD_LSB);
    i_body  = (32'(imm[11:0]) << I_IMM_LSB) | (32'(rn) << RN_LSB) | (32'(rd) << RD_LSB);
    d_body  = (32'(imm[8:0]) << D_IMM_LSB) | (32'(rn) << RN_LSB) | (32'(rd) << RD_LSB);
    cb_body = (32'(imm[18:0]) << CB_IMM_LSB) | (32'(rd) << RD_LSB);
  end

  // Opcode selection and legality per op_sel
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_sel_e'(op_sel))
      OP_ADD:  word = (32'(OPC_ADD) << R_OPC_LSB) | r_regs;
      OP_SUB:  word = (32'(OPC_SUB) << R_OPC_LSB) | r_regs;
      OP_AND:  word = (32'(OPC_AND) << R_OPC_LSB) | r_regs;
      OP_ORR:  word = (32'(OPC_ORR) << R_OPC_LSB) | r_regs;
      OP_LSL:  word = (32'(OPC_LSL) << R_OPC_LSB) | r_shift;
      OP_LSR:  word = (32'(OPC_LSR) << R_OPC_LSB) | r_shift;
      OP_LDUR: begin
        word  = (32'(OPC_LDUR) << D_OPC_LSB) | d_body;
        legal = fits_signed(imm, 9);
      end
      OP_STUR: begin
        word  = (32'(OPC_STUR) << D_OPC_LSB) | d_body;
        legal = fits_signed(imm, 9);
      end
      OP_B:    word = (32'(OPC_B) << B_OPC_LSB) | 32'(imm);
      OP_CBZ: begin
        word  = (32'(OPC_CBZ) << CB_OPC_LSB) | cb_body;
        legal = fits_signed(imm, 19);
      end
      OP_CBNZ: begin
        word  = (32'(OPC_CBNZ) << CB_OPC_LSB) | cb_body;
        legal = fits_signed(imm, 19);
      end
      OP_ADDI: begin
        word  = (32'(OPC_ADDI) << I_OPC_LSB) | i_body;
        legal = (imm[25:12] == '0);
      end
      OP_SUBI: begin
        word  = (32'(OPC_SUBI) << I_OPC_LSB) | i_body;
        legal = (imm[25:12] == '0);
      end
      OP_ANDI: begin
        word  = (32'(OPC_ANDI) << I_OPC_LSB) | i_body;
        legal = (imm[25:12] == '0);
      end
      OP_ORRI: begin
        word  = (32'(OPC_ORRI) << I_OPC_LSB) | i_body;
        legal = (imm[25:12] == '0);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded LEGv8 instructions into imem at consecutive word addresses.
module instr_encoder_loader
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [5:0]        shamt,
  input  logic [25:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pointer;
  logic [ADDR_W:0]   slots;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              write_ok;

  legv8_encode u_encode (
    .op_sel (op_sel),
    .rd     (rd),
    .rn     (rn),
    .rm     (rm),
    .shamt  (shamt),
    .imm    (imm),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // Handshake: finish takes priority over new instructions
  always_comb begin
    in_ready = (state == S_RUN) && (slots < DEPTH_C) && !finish;
    accept   = in_valid && in_ready;
    write_ok = accept && enc_legal;
  end

  // Session FSM, write pointer, slot/word counters and registered imem port.
  // The write issued on the cycle entering FULL or on a finish cycle is already
  // on the bus, so leaving to IDLE at the next edge lets it drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pointer    <= '0;
      slots      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= write_ok;
      done    <= 1'b0;
      if (write_ok) begin
        imem_addr  <= pointer;
        imem_wdata <= enc_word;
        pointer    <= pointer + ADDR_W'(1);
        count      <= count + (ADDR_W + 1)'(1);
        slots      <= slots + (ADDR_W + 1)'(1);
      end
      if (accept && !enc_legal) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            pointer <= base_addr;
            slots   <= '0;
            count   <= '0;
            err     <= 1'b0;
          end
        end
        S_RUN: begin
          if (finish) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (write_ok && (slots + (ADDR_W + 1)'(1) == DEPTH_C)) begin
            state <= S_FULL;
          end
        end
        S_FULL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4 instance).
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [5:0]        shamt;
  logic [25:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rd         (rd),
    .rn         (rn),
    .rm         (rm),
    .shamt      (shamt),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                           input logic [4:0] m, input logic [5:0] s, input logic [25:0] i);
    op_sel   = o;
    rd       = d;
    rn       = n;
    rm       = m;
    shamt    = s;
    imm      = i;
    in_valid = 1'b1;
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic end_session(input string tag);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; finish = 1'b0; in_valid = 1'b0;
    op_sel = '0; rd = '0; rn = '0; rm = '0; shamt = '0; imm = '0;
    repeat (2) step();
    chk("rst_we",    32'(imem_we),    32'd0);
    chk("rst_addr",  32'(imem_addr),  32'd0);
    chk("rst_wdata", imem_wdata,      32'd0);
    chk("rst_count", 32'(count),      32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_err",   32'(err),        32'd0);
    chk("rst_ready", 32'(in_ready),   32'd0);
    #2 rst_n = 1'b1;
    step();

    // Session A: single ADD
    begin_session(6'd0);
    chk("a_busy", 32'(busy), 32'd1);
    set_instr(4'd0, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0);
    chk("a_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("a_we",    32'(imem_we),   32'd1);
    chk("a_addr",  32'(imem_addr), 32'd0);
    chk("a_wdata", imem_wdata,     32'h8B030041);
    chk("a_count", 32'(count),     32'd1);
    step();
    chk("a_idle_we", 32'(imem_we), 32'd0);
    end_session("a");

    // Session B: back-to-back ADDI, LDUR, B, CBZ; fourth write fills DEPTH
    begin_session(6'd0);
    chk("b_err_clr", 32'(err), 32'd0);
    set_instr(4'd11, 5'd9, 5'd9, 5'd0, 6'd0, 26'd1);
    step();
    chk("b_addi_we",    32'(imem_we),   32'd1);
    chk("b_addi_addr",  32'(imem_addr), 32'd0);
    chk("b_addi_wdata", imem_wdata,     32'h91000529);
    set_instr(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'd8);
    step();
    chk("b_ldur_we",    32'(imem_we),   32'd1);
    chk("b_ldur_addr",  32'(imem_addr), 32'd1);
    chk("b_ldur_wdata", imem_wdata,     32'hF8408041);
    chk("b_count2",     32'(count),     32'd2);
    set_instr(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF);
    step();
    chk("b_b_addr",  32'(imem_addr), 32'd2);
    chk("b_b_wdata", imem_wdata,     32'h17FFFFFF);
    set_instr(4'd9, 5'd5, 5'd0, 5'd0, 6'd0, 26'd2);
    step();
    chk("b_cbz_we",    32'(imem_we),   32'd1);
    chk("b_cbz_addr",  32'(imem_addr), 32'd3);
    chk("b_cbz_wdata", imem_wdata,     32'hB4000045);
    chk("b_count4",    32'(count),     32'd4);
    chk("b_full_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("b_full_done", 32'(done),    32'd1);
    chk("b_full_busy", 32'(busy),    32'd0);
    chk("b_full_we",   32'(imem_we), 32'd0);
    step();
    chk("b_done_pulse", 32'(done), 32'd0);

    // Session C: rejections leave pointer and count alone
    begin_session(6'd5);
    set_instr(4'd11, 5'd1, 5'd1, 5'd0, 6'd0, 26'd4096);
    chk("c_rej_ready", 32'(in_ready), 32'd1);
    step();
    chk("c_i_rng_we",    32'(imem_we), 32'd0);
    chk("c_i_rng_err",   32'(err),     32'd1);
    chk("c_i_rng_count", 32'(count),   32'd0);
    set_instr(4'd15, 5'd1, 5'd1, 5'd1, 6'd0, 26'd0);
    step();
    chk("c_ill_we",  32'(imem_we), 32'd0);
    chk("c_ill_err", 32'(err),     32'd1);
    set_instr(4'd4, 5'd0, 5'd0, 5'd0, 6'd0, 26'd256);
    step();
    chk("c_d_rng_we", 32'(imem_we), 32'd0);
    set_instr(4'd14, 5'd0, 5'd0, 5'd0, 6'd0, 26'hFFF);
    step();
    chk("c_orri_we",    32'(imem_we),   32'd1);
    chk("c_orri_addr",  32'(imem_addr), 32'd5);
    chk("c_orri_wdata", imem_wdata,     32'hB23FFC00);
    chk("c_orri_count", 32'(count),     32'd1);
    chk("c_err_sticky", 32'(err),       32'd1);
    set_instr(4'd4, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFF00);
    step();
    chk("c_dneg_addr",  32'(imem_addr), 32'd6);
    chk("c_dneg_wdata", imem_wdata,     32'hF8500000);
    set_instr(4'd6, 5'd1, 5'd2, 5'd7, 6'd3, 26'd0);
    step();
    chk("c_lsl_addr",  32'(imem_addr), 32'd7);
    chk("c_lsl_wdata", imem_wdata,     32'hD3600C41);
    // finish together with a valid instruction: finish wins
    set_instr(4'd0, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0);
    finish = 1'b1;
    #1;
    chk("c_fin_ready", 32'(in_ready), 32'd0);
    step();
    finish = 1'b0;
    in_valid = 1'b0;
    chk("c_fin_we",   32'(imem_we), 32'd0);
    chk("c_fin_done", 32'(done),    32'd1);
    chk("c_fin_count", 32'(count),  32'd3);

    // Session D: wrap from 62, fifth instruction refused
    begin_session(6'd62);
    for (int i = 0; i < 4; i++) begin
      set_instr(4'd0, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0);
      chk($sformatf("d_ready%0d", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("d_addr%0d", i), 32'(imem_addr), 32'((62 + i) % 64));
      chk($sformatf("d_we%0d", i),   32'(imem_we),   32'd1);
    end
    chk("d_ready4", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    chk("d_we4",   32'(imem_we), 32'd0);
    chk("d_done",  32'(done),    32'd1);
    chk("d_busy",  32'(busy),    32'd0);
    chk("d_count", 32'(count),   32'd4);

    // Session E: reset while a write is on the bus
    step();
    begin_session(6'd10);
    set_instr(4'd0, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0);
    step();
    in_valid = 1'b0;
    chk("e_pre_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("e_rst_we",    32'(imem_we),   32'd0);
    chk("e_rst_addr",  32'(imem_addr), 32'd0);
    chk("e_rst_wdata", imem_wdata,     32'd0);
    chk("e_rst_count", 32'(count),     32'd0);
    chk("e_rst_busy",  32'(busy),      32'd0);
    step();
    chk("e_hold_we", 32'(imem_we), 32'd0);
    #2 rst_n = 1'b1;
    step();
    begin_session(6'd3);
    set_instr(4'd1, 5'd4, 5'd5, 5'd6, 6'd0, 26'd0);
    step();
    in_valid = 1'b0;
    chk("e_new_addr",  32'(imem_addr), 32'd3);
    chk("e_new_wdata", imem_wdata,     32'hCB0600A4);
    chk("e_new_count", 32'(count),     32'd1);
    end_session("e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
